vga_sync_monitor: RTL

- Receive-side checker for the VGA timing that the display path drives.
- Samples vga_h_sync, vga_v_sync and the colour bits on the pixel clock enable, then recovers pixel X/Y and checks line and frame lengths against 640x480 timing.
- Also counts lit pixels per frame.
- Sits in loopback beside the sync generator, for on-board self-test (LEDs/SSD) and for simulation benches of the arrow and target drawing logic.

---
 rtl/vga_sync_monitor.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for the VGA timing driven by the
// display path. Registers sync and colour on pix_ce, recovers X/Y, checks
// line/frame lengths, tracks lock and counts lit pixels per frame.
// Optional build macro VGA_MON_CRC_EN adds a per-frame CRC-16-CCITT over the
// visible pixels; without it frame_crc is tied to zero.
module vga_sync_monitor #(
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int H_ACTIVE        = 640,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int V_ACTIVE        = 480,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic [2:0]  vga_r,
  input  logic        vga_g,
  input  logic        vga_b,
  output logic [9:0]  mon_x,
  output logic [9:0]  mon_y,
  output logic        mon_active,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic        frame_done,
  output logic [18:0] lit_count,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam logic [9:0]  H_ST  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_EN  = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_ST  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_EN  = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] H_LEN = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN = 11'(V_TOTAL);
  localparam logic        POL   = 1'(SYNC_ACTIVE_LOW);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state;
  logic [1:0]  good_cnt;
  logic        h_armed;

  // input sample stage (sync normalised to active-high)
  logic        hs_s, hs_d, vs_s, vs_d;
  logic [4:0]  rgb_s;

  logic [9:0]  h_cnt, v_cnt;
  logic [18:0] lit_acc;

  logic        h_edge, v_edge;
  logic [9:0]  h_nxt, v_nxt;
  logic        line_bad, frame_bad, err_any;
  logic        act_nxt, lit_px;
  logic [8:0]  err_sum;

  // register pins once per pixel and keep the previous sample for edge detect
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      hs_s  <= 1'b0;
      hs_d  <= 1'b0;
      vs_s  <= 1'b0;
      vs_d  <= 1'b0;
      rgb_s <= '0;
    end else if (pix_ce) begin
      hs_s  <= vga_h_sync ^ POL;
      hs_d  <= hs_s;
      vs_s  <= vga_v_sync ^ POL;
      vs_d  <= vs_s;
      rgb_s <= {vga_r, vga_g, vga_b};
    end
  end

  // edge detect, next counter values, length checks and visible-window decode
  always_comb begin
    h_edge = hs_s & ~hs_d;
    v_edge = vs_s & ~vs_d;

    h_nxt = (h_cnt == 10'h3FF) ? h_cnt : h_cnt + 10'd1;
    if (h_edge) h_nxt = '0;

    // vsync edge is applied after the hsync edge when both coincide
    v_nxt = v_cnt;
    if (h_edge && v_cnt != 10'h3FF) v_nxt = v_cnt + 10'd1;
    if (v_edge) v_nxt = '0;

    // counters hold the last index of the line/frame, so length = cnt + 1
    line_bad  = h_edge && h_armed && (({1'b0, h_cnt} + 11'd1) != H_LEN);
    frame_bad = v_edge && (state != SEARCH) && (({1'b0, v_cnt} + 11'd1) != V_LEN);
    err_any   = line_bad | frame_bad;

    act_nxt = (h_nxt >= H_ST) && (h_nxt < H_EN) && (v_nxt >= V_ST) && (v_nxt < V_EN);
    lit_px  = act_nxt && (rgb_s != 5'd0);

    err_sum = {1'b0, err_count} + {8'd0, line_bad} + {8'd0, frame_bad};
  end

  // position counters, recovered coordinates and error pulses
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      mon_x      <= '0;
      mon_y      <= '0;
      mon_active <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_ce) begin
        h_cnt      <= h_nxt;
        v_cnt      <= v_nxt;
        mon_active <= act_nxt;
        mon_x      <= act_nxt ? h_nxt - H_ST : '0;
        mon_y      <= act_nxt ? v_nxt - V_ST : '0;
        line_err   <= line_bad;
        frame_err  <= frame_bad;
        frame_done <= v_edge;
        err_count  <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
    end
  end

  // lock FSM: SEARCH -> ACQUIRE on vsync, LOCKED after 2 clean frames
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      h_armed  <= 1'b0;
    end else if (pix_ce) begin
      if (h_edge) h_armed <= 1'b1;
      case (state)
        SEARCH: begin
          if (v_edge && !err_any) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (err_any) begin
            state   <= SEARCH;
            h_armed <= 1'b0;
          end else if (v_edge) begin
            if (good_cnt == 2'd1) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= 2'd2;
            end else begin
              good_cnt <= good_cnt + 2'd1;
            end
          end
        end
        LOCKED: begin
          if (err_any) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            h_armed <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // lit-pixel accumulator, latched and cleared at each vsync leading edge
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      lit_acc   <= '0;
      lit_count <= '0;
    end else if (pix_ce) begin
      if (v_edge) begin
        lit_count <= lit_acc;
        lit_acc   <= {18'd0, lit_px};
      end else if (lit_px) begin
        lit_acc <= lit_acc + 19'd1;
      end
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc;

  // fold 5 colour bits MSB first into CRC-16-CCITT (poly 0x1021)
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [4:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 4; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // per-frame CRC over visible samples, latched at the vsync leading edge
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else if (pix_ce) begin
      if (v_edge) begin
        frame_crc <= crc;
        crc       <= act_nxt ? crc_fold(16'hFFFF, rgb_s) : 16'hFFFF;
      end else if (act_nxt) begin
        crc <= crc_fold(crc, rgb_s);
      end
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule
